// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and decode helper for the accumulator CPU.
package acc_cpu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_NOT  = 8'h07;
    localparam logic [7:0] OP_SHL  = 8'h08;
    localparam logic [7:0] OP_SHR  = 8'h09;
    localparam logic [7:0] OP_HALT = 8'h0A;
    localparam logic [7:0] OP_JMP  = 8'h0B;
    localparam logic [7:0] OP_JZ   = 8'h0C;
    localparam logic [7:0] OP_JC   = 8'h0D;
    localparam logic [7:0] OP_ADC  = 8'h0E;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } cpu_state_e;

    function automatic logic is_defined_op(input logic [7:0] op);
        return (op <= OP_ADC);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the new accumulator and carry for one opcode,
// and reports which architectural registers that opcode is allowed to write.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] operand,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              c_out,
    output logic              z_out,
    output logic              writes_ac,
    output logic              writes_c
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide      = '0;
        result    = ac;
        c_out     = c_in;
        writes_ac = 1'b0;
        writes_c  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                result    = operand;
                writes_ac = 1'b1;
            end
            OP_ADD: begin
                wide      = {1'b0, ac} + {1'b0, operand};
                result    = wide[DATA_W-1:0];
                c_out     = wide[DATA_W];
                writes_ac = 1'b1;
                writes_c  = 1'b1;
            end
            OP_SUB: begin
                // The extra top bit of the difference is the borrow.
                wide      = {1'b0, ac} - {1'b0, operand};
                result    = wide[DATA_W-1:0];
                c_out     = wide[DATA_W];
                writes_ac = 1'b1;
                writes_c  = 1'b1;
            end
            OP_AND: begin
                result    = ac & operand;
                writes_ac = 1'b1;
            end
            OP_OR: begin
                result    = ac | operand;
                writes_ac = 1'b1;
            end
            OP_XOR: begin
                result    = ac ^ operand;
                writes_ac = 1'b1;
            end
            OP_NOT: begin
                result    = ~ac;
                writes_ac = 1'b1;
            end
            OP_SHL: begin
                result    = {ac[DATA_W-2:0], 1'b0};
                c_out     = ac[DATA_W-1];
                writes_ac = 1'b1;
                writes_c  = 1'b1;
            end
            OP_SHR: begin
                result    = {1'b0, ac[DATA_W-1:1]};
                c_out     = ac[0];
                writes_ac = 1'b1;
                writes_c  = 1'b1;
            end
            OP_ADC: begin
                wide      = {1'b0, ac} + {1'b0, operand} + {{DATA_W{1'b0}}, c_in};
                result    = wide[DATA_W-1:0];
                c_out     = wide[DATA_W];
                writes_ac = 1'b1;
                writes_c  = 1'b1;
            end
            default: ;
        endcase
    end

    assign z_out = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Two-word-instruction accumulator CPU: program memory, PC, FSM and flags.
// Operands wider than ADDR_W are truncated to form jump targets.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              run,
    input  logic              restart,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              halted,
    output logic              illegal,
    output cpu_state_e        state_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd;

    cpu_state_e        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [DATA_W-1:0] ac, ac_nxt;
    logic [DATA_W-1:0] operand, operand_nxt;
    logic [7:0]        opcode, opcode_nxt;
    logic              z, z_nxt, c, c_nxt, ill, ill_nxt;

    logic [DATA_W-1:0] alu_result;
    logic              alu_c, alu_z, alu_writes_ac, alu_writes_c;
    logic              enable;

    // Restart beats a simultaneous load, so the write is dropped in that case.
    always_ff @(posedge clk) begin
        if (load_we && !restart) begin
            mem[load_addr] <= load_data;
        end
    end

    assign mem_rd = mem[pc];
    assign enable = run && !load_we && !restart;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode    (opcode),
        .ac        (ac),
        .operand   (operand),
        .c_in      (c),
        .result    (alu_result),
        .c_out     (alu_c),
        .z_out     (alu_z),
        .writes_ac (alu_writes_ac),
        .writes_c  (alu_writes_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= '0;
            ac      <= '0;
            operand <= '0;
            opcode  <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            ill     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ac      <= ac_nxt;
            operand <= operand_nxt;
            opcode  <= opcode_nxt;
            z       <= z_nxt;
            c       <= c_nxt;
            ill     <= ill_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ac_nxt      = ac;
        operand_nxt = operand;
        opcode_nxt  = opcode;
        z_nxt       = z;
        c_nxt       = c;
        ill_nxt     = ill;
        if (restart) begin
            state_nxt = FETCH;
            pc_nxt    = '0;
        end else if (enable) begin
            case (state)
                FETCH: begin
                    opcode_nxt = mem_rd[7:0];
                    pc_nxt     = pc + ADDR_W'(1);
                    state_nxt  = DECODE;
                end
                DECODE: begin
                    operand_nxt = mem_rd;
                    pc_nxt      = pc + ADDR_W'(1);
                    state_nxt   = EXECUTE;
                end
                EXECUTE: begin
                    state_nxt = FETCH;
                    case (opcode)
                        OP_HALT: state_nxt = HALT;
                        OP_JMP:  pc_nxt = operand[ADDR_W-1:0];
                        OP_JZ:   if (z) pc_nxt = operand[ADDR_W-1:0];
                        OP_JC:   if (c) pc_nxt = operand[ADDR_W-1:0];
                        default: begin
                            if (!is_defined_op(opcode)) begin
                                state_nxt = HALT;
                                ill_nxt   = 1'b1;
                            end
                        end
                    endcase
                    if (alu_writes_ac) begin
                        ac_nxt = alu_result;
                        z_nxt  = alu_z;
                    end
                    if (alu_writes_c) begin
                        c_nxt = alu_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_out    = ac;
    assign pc_out     = pc;
    assign zero_flag  = z;
    assign carry_flag = c;
    assign halted     = (state == HALT);
    assign illegal    = ill;
    assign state_dbg  = state;

endmodule
